mar_ram: RTL

MAR_RAM -- requirements
Module: mar_ram

---
 rtl/mar_ram.sv | 112 +++++++++++
 1 files changed

// File: rtl/mar_ram.sv
// mar_ram: 16x8 RAM addressed by a 4-bit MAR, with a sequential program loader.
// Build macro MAR_RAM_WRITE_EN adds a direct write port (we) usable in RUN.
module mar_ram (
   input  logic       clk,
   input  logic       clr,
   input  logic [7:0] wbus,
   input  logic       lm,
   input  logic       ce,
`ifdef MAR_RAM_WRITE_EN
   input  logic       we,
`endif
   input  logic       prog,
   input  logic       prog_valid,
   input  logic [7:0] prog_data,
   output logic [7:0] ramout,
   output logic [3:0] mar_out,
   output logic       prog_ready,
   output logic       prog_done
);

   // state | meaning
   // RUN   | normal operation: MAR load, RAM read onto bus, optional direct write
   // LOAD  | loader accepting bytes into RAM[ptr], ptr counting 0..15
   // DONE  | all 16 locations loaded, further beats dropped until prog drops
   typedef enum logic [1:0] {
      RUN  = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] mar_q, mar_d;
   logic [3:0] ptr_q, ptr_d;
   logic [7:0] mem [16];
   logic       wr_en;
   logic [3:0] wr_addr;
   logic [7:0] wr_data;
   logic       we_i;

`ifdef MAR_RAM_WRITE_EN
   assign we_i = we;
`else
   assign we_i = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      mar_d   = mar_q;
      ptr_d   = ptr_q;
      wr_en   = 1'b0;
      wr_addr = mar_q;
      wr_data = wbus;
      case (state_q)
         RUN: begin
            wr_en = we_i;
            if (lm) mar_d = wbus[3:0];
            if (prog) begin
               state_d = LOAD;
               ptr_d   = 4'd0;
            end
         end
         LOAD: begin
            if (!prog) begin
               state_d = RUN;
               ptr_d   = 4'd0;
            end else if (prog_valid) begin
               wr_en   = 1'b1;
               wr_addr = ptr_q;
               wr_data = prog_data;
               // last beat parks in DONE instead of wrapping onto address 0
               if (ptr_q == 4'd15) state_d = DONE;
               else                ptr_d   = ptr_q + 4'd1;
            end
         end
         DONE: begin
            if (!prog) begin
               state_d = RUN;
               ptr_d   = 4'd0;
            end
         end
         default: begin
            state_d = RUN;
            ptr_d   = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q    <= RUN;
         mar_q      <= 4'd0;
         ptr_q      <= 4'd0;
         prog_ready <= 1'b0;
         prog_done  <= 1'b0;
      end else begin
         state_q    <= state_d;
         mar_q      <= mar_d;
         ptr_q      <= ptr_d;
         prog_ready <= (state_d == LOAD);
         prog_done  <= (state_d == DONE);
      end
   end

   // RAM has no reset: contents survive clr
   always_ff @(posedge clk) begin
      if (wr_en && !clr) mem[wr_addr] <= wr_data;
   end

   assign ramout  = (state_q == RUN && ce) ? mem[mar_q] : 8'bzzzz_zzzz;
   assign mar_out = mar_q;

endmodule
